// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter onto a single burst memory port.
// Round-robin on ties, one turnaround IDLE cycle between transactions, and a silence watchdog.
module mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ic_rdaddr,
    input  logic        ic_rdreq,
    output logic [31:0] ic_dataout,
    output logic        ic_datavalid,
    output logic [15:0] ic_burstlen,
    input  logic [31:0] dc_addr,
    input  logic        dc_rdreq,
    input  logic        dc_wrreq,
    input  logic [31:0] dc_datain,
    output logic [31:0] dc_dataout,
    output logic        dc_datavalid,
    output logic        dc_wrack,
    output logic [15:0] dc_burstlen,
    output logic [31:0] mem_addr,
    output logic        mem_rdreq,
    output logic        mem_wrreq,
    output logic [31:0] mem_datain,
    input  logic [15:0] mem_burstlen,
    input  logic [31:0] mem_dataout,
    input  logic        mem_datavalid,
    input  logic        mem_wrack,
    output logic        err_timeout
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BUSY_RD = 2'd2,
        BUSY_WR = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        ic_pend_q, ic_pend_d, dc_pend_q, dc_pend_d, dc_wr_q, dc_wr_d;
    logic [31:0] ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d, dc_data_q, dc_data_d;
    logic        last_dc_q, last_dc_d, sel_dc_q, sel_dc_d, sel_wr_q, sel_wr_d;
    logic [15:0] target_q, target_d, beat_q, beat_d, wd_q, wd_d;
    logic        mem_rdreq_q, mem_rdreq_d, mem_wrreq_q, mem_wrreq_d, err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_datain_q, mem_datain_d;
    logic        ic_clr_s, dc_clr_s, pick_dc_s, ic_own_s, dc_own_s, ic_cap_s, dc_cap_s;
    logic        wd_exp_s;

    assign pick_dc_s = dc_pend_q && (!ic_pend_q || !last_dc_q);
    assign ic_own_s  = (state_q != IDLE) && !sel_dc_q;
    assign dc_own_s  = (state_q != IDLE) && sel_dc_q;
    assign ic_cap_s  = ic_rdreq && !ic_pend_q && !ic_own_s;
    assign dc_cap_s  = (dc_rdreq || dc_wrreq) && !dc_pend_q && !dc_own_s;
    assign wd_exp_s  = (wd_q + 16'd1) == TIMEOUT_C;

    // Next-state and registered-output logic of the arbitration FSM
    always_comb begin
        state_d      = state_q;
        last_dc_d    = last_dc_q;
        sel_dc_d     = sel_dc_q;
        sel_wr_d     = sel_wr_q;
        target_d     = target_q;
        beat_d       = beat_q;
        wd_d         = wd_q;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        mem_rdreq_d  = 1'b0;
        mem_wrreq_d  = 1'b0;
        err_d        = 1'b0;
        ic_clr_s     = 1'b0;
        dc_clr_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_pend_q || dc_pend_q) begin
                    state_d  = ISSUE;
                    sel_dc_d = pick_dc_s;
                    if (pick_dc_s) begin
                        dc_clr_s   = 1'b1;
                        sel_wr_d   = dc_wr_q;
                        mem_addr_d = dc_addr_q;
                        if (dc_wr_q) begin
                            mem_wrreq_d  = 1'b1;
                            mem_datain_d = dc_data_q;
                        end else begin
                            mem_rdreq_d = 1'b1;
                        end
                    end else begin
                        ic_clr_s    = 1'b1;
                        sel_wr_d    = 1'b0;
                        mem_addr_d  = ic_addr_q;
                        mem_rdreq_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                target_d = (mem_burstlen == 16'd0) ? 16'd1 : mem_burstlen;
                beat_d   = 16'd0;
                wd_d     = 16'd0;
                state_d  = sel_wr_q ? BUSY_WR : BUSY_RD;
            end
            BUSY_RD: begin
                if (mem_datavalid) begin
                    beat_d = beat_q + 16'd1;
                    wd_d   = 16'd0;
                    if ((beat_q + 16'd1) == target_q) begin
                        state_d   = IDLE;
                        last_dc_d = sel_dc_q;
                    end else begin
                        state_d = BUSY_RD;
                    end
                end else if (wd_exp_s) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    last_dc_d = sel_dc_q;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            BUSY_WR: begin
                if (mem_wrack) begin
                    state_d   = IDLE;
                    wd_d      = 16'd0;
                    last_dc_d = sel_dc_q;
                end else if (wd_exp_s) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    last_dc_d = sel_dc_q;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture; a pulse is only taken when the requester is neither pending nor owning the bus
    always_comb begin
        if (ic_cap_s) begin
            ic_pend_d = 1'b1;
            ic_addr_d = ic_rdaddr;
        end else begin
            ic_pend_d = ic_pend_q && !ic_clr_s;
            ic_addr_d = ic_addr_q;
        end
        if (dc_cap_s) begin
            dc_pend_d = 1'b1;
            dc_wr_d   = dc_wrreq;
            dc_addr_d = dc_addr;
            dc_data_d = dc_datain;
        end else begin
            dc_pend_d = dc_pend_q && !dc_clr_s;
            dc_wr_d   = dc_wr_q;
            dc_addr_d = dc_addr_q;
            dc_data_d = dc_data_q;
        end
    end

    // State and capture registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ic_pend_q    <= 1'b0;
            ic_addr_q    <= 32'd0;
            dc_pend_q    <= 1'b0;
            dc_wr_q      <= 1'b0;
            dc_addr_q    <= 32'd0;
            dc_data_q    <= 32'd0;
            last_dc_q    <= 1'b0;
            sel_dc_q     <= 1'b0;
            sel_wr_q     <= 1'b0;
            target_q     <= 16'd0;
            beat_q       <= 16'd0;
            wd_q         <= 16'd0;
            mem_rdreq_q  <= 1'b0;
            mem_wrreq_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_datain_q <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ic_pend_q    <= ic_pend_d;
            ic_addr_q    <= ic_addr_d;
            dc_pend_q    <= dc_pend_d;
            dc_wr_q      <= dc_wr_d;
            dc_addr_q    <= dc_addr_d;
            dc_data_q    <= dc_data_d;
            last_dc_q    <= last_dc_d;
            sel_dc_q     <= sel_dc_d;
            sel_wr_q     <= sel_wr_d;
            target_q     <= target_d;
            beat_q       <= beat_d;
            wd_q         <= wd_d;
            mem_rdreq_q  <= mem_rdreq_d;
            mem_wrreq_q  <= mem_wrreq_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
            err_q        <= err_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_datain   = mem_datain_q;
    assign mem_rdreq    = mem_rdreq_q;
    assign mem_wrreq    = mem_wrreq_q;
    assign err_timeout  = err_q;
    assign ic_dataout   = mem_dataout;
    assign dc_dataout   = mem_dataout;
    assign ic_burstlen  = mem_burstlen;
    assign dc_burstlen  = mem_burstlen;
    assign ic_datavalid = mem_datavalid && (state_q == BUSY_RD) && !sel_dc_q;
    assign dc_datavalid = mem_datavalid && (state_q == BUSY_RD) && sel_dc_q;
    assign dc_wrack     = mem_wrack && (state_q == BUSY_WR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ic_rdaddr, dc_addr, dc_datain, mem_dataout;
    logic        ic_rdreq, dc_rdreq, dc_wrreq, mem_datavalid, mem_wrack;
    logic [15:0] mem_burstlen;
    logic [31:0] ic_dataout, dc_dataout, mem_addr, mem_datain;
    logic        ic_datavalid, dc_datavalid, dc_wrack, mem_rdreq, mem_wrreq, err_timeout;
    logic [15:0] ic_burstlen, dc_burstlen;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ic_rdaddr(ic_rdaddr), .ic_rdreq(ic_rdreq), .ic_dataout(ic_dataout),
        .ic_datavalid(ic_datavalid), .ic_burstlen(ic_burstlen),
        .dc_addr(dc_addr), .dc_rdreq(dc_rdreq), .dc_wrreq(dc_wrreq), .dc_datain(dc_datain),
        .dc_dataout(dc_dataout), .dc_datavalid(dc_datavalid), .dc_wrack(dc_wrack),
        .dc_burstlen(dc_burstlen),
        .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_datain(mem_datain),
        .mem_burstlen(mem_burstlen), .mem_dataout(mem_dataout), .mem_datavalid(mem_datavalid),
        .mem_wrack(mem_wrack), .err_timeout(err_timeout)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: pending requests, the transaction in flight, and arbitration history
    logic        m_ic_pend, m_dc_pend, m_dc_wr, m_last_dc;
    logic [31:0] m_ic_addr, m_dc_addr, m_dc_data, m_addr_o, m_din_o;
    logic        m_issue, m_busy, m_cur_dc, m_cur_wr, m_err;
    int          m_left, m_silent;

    // Observations used by the directed scenarios
    logic [31:0] iss_addr[$];
    int          iss_cyc[$];
    int          n_icdv, n_dcdv, n_wrack, wrack_cyc, err_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ic_pend = 1'b0; m_dc_pend = 1'b0; m_dc_wr = 1'b0; m_last_dc = 1'b0;
        m_ic_addr = 32'd0; m_dc_addr = 32'd0; m_dc_data = 32'd0;
        m_addr_o = 32'd0; m_din_o = 32'd0;
        m_issue = 1'b0; m_busy = 1'b0; m_cur_dc = 1'b0; m_cur_wr = 1'b0; m_err = 1'b0;
        m_left = 0; m_silent = 0;
    endtask

    task automatic clear_obs();
        iss_addr.delete(); iss_cyc.delete();
        n_icdv = 0; n_dcdv = 0; n_wrack = 0; wrack_cyc = -1; err_cyc = -1;
    endtask

    function automatic logic [31:0] iss_a(input int i);
        return (iss_addr.size() > i) ? iss_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int iss_c(input int i);
        return (iss_cyc.size() > i) ? iss_cyc[i] : -1;
    endfunction

    // One clock cycle: drive, check against the model, then advance the model across the edge
    task automatic step(input logic rb, input logic icr, input logic [31:0] ica,
                        input logic dcr, input logic dcw, input logic [31:0] dca,
                        input logic [31:0] dcd, input logic [15:0] bl, input logic dv,
                        input logic wa, input logic [31:0] md);
        logic own_ic, own_dc, cap_ic, cap_dc, fin, take_dc;
        @(negedge clk);
        reset_n = rb; ic_rdreq = icr; ic_rdaddr = ica; dc_rdreq = dcr; dc_wrreq = dcw;
        dc_addr = dca; dc_datain = dcd; mem_burstlen = bl; mem_datavalid = dv;
        mem_wrack = wa; mem_dataout = md;
        #1;
        check_eq("mem_rdreq", 32'(mem_rdreq), 32'(m_issue && !m_cur_wr));
        check_eq("mem_wrreq", 32'(mem_wrreq), 32'(m_issue && m_cur_wr));
        check_eq("mem_addr", mem_addr, m_addr_o);
        check_eq("mem_datain", mem_datain, m_din_o);
        check_eq("ic_datavalid", 32'(ic_datavalid), 32'(dv && m_busy && !m_cur_wr && !m_cur_dc));
        check_eq("dc_datavalid", 32'(dc_datavalid), 32'(dv && m_busy && !m_cur_wr && m_cur_dc));
        check_eq("dc_wrack", 32'(dc_wrack), 32'(wa && m_busy && m_cur_wr));
        check_eq("err_timeout", 32'(err_timeout), 32'(m_err));
        check_eq("ic_dataout", ic_dataout, md);
        check_eq("dc_dataout", dc_dataout, md);
        check_eq("burstlen", {ic_burstlen, dc_burstlen}, {bl, bl});

        if (mem_rdreq || mem_wrreq) begin
            iss_addr.push_back(mem_addr);
            iss_cyc.push_back(cyc);
        end
        if (ic_datavalid) n_icdv++;
        if (dc_datavalid) n_dcdv++;
        if (dc_wrack) begin n_wrack++; wrack_cyc = cyc; end
        if (err_timeout) err_cyc = cyc;

        if (!rb) begin
            model_reset();
        end else begin
            own_ic = (m_issue || m_busy) && !m_cur_dc;
            own_dc = (m_issue || m_busy) && m_cur_dc;
            cap_ic = icr && !m_ic_pend && !own_ic;
            cap_dc = (dcr || dcw) && !m_dc_pend && !own_dc;
            m_err  = 1'b0;
            fin    = 1'b0;
            if (m_busy) begin
                if (m_cur_wr ? wa : dv) begin
                    m_silent = 0;
                    if (m_cur_wr) fin = 1'b1;
                    else begin m_left--; fin = (m_left == 0); end
                end else begin
                    m_silent++;
                    if (m_silent == TO) begin fin = 1'b1; m_err = 1'b1; end
                end
                if (fin) begin m_busy = 1'b0; m_last_dc = m_cur_dc; end
            end else if (m_issue) begin
                m_issue = 1'b0; m_busy = 1'b1; m_silent = 0;
                m_left = (bl == 16'd0) ? 1 : int'(bl);
            end else if (m_ic_pend || m_dc_pend) begin
                take_dc  = m_dc_pend && (!m_ic_pend || !m_last_dc);
                m_issue  = 1'b1;
                m_cur_dc = take_dc;
                if (take_dc) begin
                    m_cur_wr = m_dc_wr; m_addr_o = m_dc_addr; m_dc_pend = 1'b0;
                    if (m_dc_wr) m_din_o = m_dc_data;
                end else begin
                    m_cur_wr = 1'b0; m_addr_o = m_ic_addr; m_ic_pend = 1'b0;
                end
            end
            if (cap_ic) begin m_ic_pend = 1'b1; m_ic_addr = ica; end
            if (cap_dc) begin
                m_dc_pend = 1'b1; m_dc_wr = dcw; m_dc_addr = dca; m_dc_data = dcd;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd1, 1'b0, 1'b0, 32'd0);
        clear_obs();
    endtask

    initial begin
        int t0;
        reset_n = 1'b0; ic_rdreq = 1'b0; ic_rdaddr = 32'd0; dc_rdreq = 1'b0; dc_wrreq = 1'b0;
        dc_addr = 32'd0; dc_datain = 32'd0; mem_burstlen = 16'd0; mem_datavalid = 1'b0;
        mem_wrack = 1'b0; mem_dataout = 32'd0;
        repeat (3) @(posedge clk);
        model_reset();
        clear_obs();

        // 32-beat icache read
        do_reset();
        t0 = cyc;
        step(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0, 16'd32, 1'b0, 1'b0, $urandom);
        for (int k = 1; k <= 41; k++)
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd32, 1'b1, 1'b0, $urandom);
        check_eq("ic_issue_count", 32'(iss_addr.size()), 32'd1);
        check_eq("ic_issue_addr", iss_a(0), 32'h1000);
        check_eq("ic_issue_latency", 32'(iss_c(0) - t0), 32'd2);
        check_eq("ic_beats", 32'(n_icdv), 32'd32);
        check_eq("ic_no_dc_beats", 32'(n_dcdv), 32'd0);

        // Simultaneous requests: dcache first, icache after turnaround, then round-robin
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 20; k++)
            step(1'b1, (k == 0 || k == 9), 32'h100, (k == 0 || k == 9), 1'b0, 32'h200, 32'd0,
                 16'd2, 1'b1, 1'b0, $urandom);
        check_eq("tie_first", iss_a(0), 32'h200);
        check_eq("tie_second", iss_a(1), 32'h100);
        check_eq("tie_second_cycle", 32'(iss_c(1) - t0), 32'd6);
        check_eq("tie2_first", iss_a(2), 32'h200);
        check_eq("tie2_second", iss_a(3), 32'h100);

        // dcache write acknowledged five cycles after issue
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b0, 32'd0, 1'b0, (k == 0), 32'h20, 32'hDEAD_BEEF, 16'd4, 1'b0,
                 (k == 7), $urandom);
        check_eq("wr_issue_cycle", 32'(iss_c(0) - t0), 32'd2);
        check_eq("wr_issue_addr", iss_a(0), 32'h20);
        check_eq("wr_ack_count", 32'(n_wrack), 32'd1);
        check_eq("wr_ack_cycle", 32'(wrack_cyc - t0), 32'd7);

        // Zero burst length is one beat
        do_reset();
        for (int k = 0; k < 8; k++)
            step(1'b1, (k == 0), 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, $urandom);
        check_eq("bl0_beats", 32'(n_icdv), 32'd1);

        // Silent read times out, then the queued dcache read goes out
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 16; k++)
            step(1'b1, (k == 0), 32'h500, (k == 4), 1'b0, 32'h600, 32'd0, 16'd4, 1'b0, 1'b0,
                 $urandom);
        check_eq("to_err_cycle", 32'(err_cyc - t0), 32'd11);
        check_eq("to_next_addr", iss_a(1), 32'h600);
        check_eq("to_next_cycle", 32'(iss_c(1) - t0), 32'd12);

        // Reset on the tenth beat of a 32-beat read
        do_reset();
        for (int k = 0; k < 23; k++)
            step((k != 12), (k == 0), 32'h3000, 1'b0, 1'b0, 32'd0, 32'd0, 16'd32, (k >= 3), 1'b0,
                 $urandom);
        check_eq("rst_mid_beats", 32'(n_icdv), 32'd10);

        // Random traffic
        do_reset();
        for (int k = 0; k < 2500; k++)
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), $urandom, $urandom,
                 16'($urandom_range(0, 5)), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) == 0), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
